// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_unit
//  Brief    : Instruction-fetch stage. Owns the PC, drives the ROM address,
//             captures ROM words into a small prefetch FIFO and hands
//             {instr, pc} to decode over valid/ready. Redirect flushes.
//  Options  : IFETCH_BYPASS_EN - when defined, an empty FIFO forwards the
//             ROM word straight to decode (0-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rd_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]      fifo_instr_q [FIFO_DEPTH];

  logic fifo_nonempty;
  logic bypass_act;
  logic bypass_take;
  logic pop;
  logic fifo_pop;
  logic push;
  logic advance;

  // The ROM is read combinationally from the live PC.
  assign imem_addr_o   = pc_q;
  assign fifo_nonempty = (count_q != '0);

`ifdef IFETCH_BYPASS_EN
  // Empty FIFO: forward the word being read right now (never in reset).
  assign bypass_act = !fifo_nonempty && !redirect_i && !rst_i;
`else
  assign bypass_act = 1'b0;
`endif

  // Output mux: FIFO head when occupied, else bypass word, else zeros.
  always_comb begin
    instr_valid_o = 1'b0;
    instr_o       = 32'h0;
    instr_pc_o    = 32'h0;
    if (fifo_nonempty) begin
      instr_valid_o = !redirect_i;
      instr_o       = fifo_instr_q[rd_ptr_q];
      instr_pc_o    = fifo_pc_q[rd_ptr_q];
    end else if (bypass_act) begin
      instr_valid_o = 1'b1;
      instr_o       = imem_rd_i;
      instr_pc_o    = pc_q;
    end
  end

  // A bypassed word that is accepted is consumed without touching the FIFO.
  assign pop         = instr_valid_o & instr_ready_i;
  assign bypass_take = bypass_act & instr_ready_i;
  assign fifo_pop    = pop & fifo_nonempty;
  assign push        = !redirect_i & ((count_q < FULL_CNT) | pop) & !bypass_take;
  assign advance     = push | bypass_take;

  // Next-state for PC, pointers and occupancy; redirect flushes everything.
  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      pc_d     = {redirect_pc_i[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (advance)  pc_d     = pc_q + 32'd4;
      if (push)     wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, fifo_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers; reset dominates redirect and handshakes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only meaningful under count_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rd_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_unit
//  Brief    : Self-checking bench for ifetch_unit (default build): directed
//             vector table, a ready-toggling sequence and randomized traffic
//             checked against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rd = rom(imem_addr);

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_addr_o   (imem_addr),
    .imem_rd_i     (imem_rd),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: next fetch PC plus a queue of fetched {pc, instr}.
  logic [31:0] m_pc;
  logic [31:0] m_qpc [$];
  logic [31:0] m_qin [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst_i       = r;
    redirect_i  = rd;
    redirect_pc = rpc;
    instr_ready = rdy;
    #1;
  endtask

  task automatic model_check();
    logic ev;
    ev = (m_qpc.size() > 0) && !redirect_i;
    chk("valid", {31'b0, instr_valid}, {31'b0, ev});
    chk("imem_addr", imem_addr, m_pc);
    if (m_qpc.size() == 0) begin
      chk("instr_empty", instr, 32'h0);
      chk("pc_empty", instr_pc, 32'h0);
    end else if (ev) begin
      chk("instr", instr, m_qin[0]);
      chk("instr_pc", instr_pc, m_qpc[0]);
    end
  endtask

  // Advance the model across the coming rising edge using the held inputs.
  task automatic model_step();
    bit do_pop, do_push;
    @(posedge clk);
    if (rst_i) begin
      m_pc = RESET_PC;
      m_qpc.delete();
      m_qin.delete();
    end else if (redirect_i) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_qpc.delete();
      m_qin.delete();
    end else begin
      do_pop  = (m_qpc.size() > 0) && instr_ready;
      do_push = (m_qpc.size() < DEPTH) || do_pop;
      if (do_pop) begin
        void'(m_qpc.pop_front());
        void'(m_qin.pop_front());
      end
      if (do_push) begin
        m_qpc.push_back(m_pc);
        m_qin.push_back(rom(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic        cd;   // compare instr/pc too
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ea;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(logic r, logic rd, logic [31:0] rpc, logic rdy,
                              logic ev, logic cd, logic [31:0] ep, logic [31:0] ei,
                              logic [31:0] ea);
    vec_t v;
    v.rst = r; v.rd = rd; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.cd = cd; v.ei = ei; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  initial begin
    logic [31:0] prev_pc;
    bit          have_prev;

    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
    m_pc = RESET_PC;

    //            rst rd  rpc           rdy ev cd  pc            instr         addr
    tbl[0]  = mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 1, 1, 32'h0,        32'h1000_0000, 32'h4);
    tbl[2]  = mk(0, 0, 32'h0,        1, 1, 1, 32'h4,        32'h1000_0001, 32'h8);
    tbl[3]  = mk(0, 0, 32'h0,        1, 1, 1, 32'h8,        32'h1000_0002, 32'hC);
    tbl[4]  = mk(0, 0, 32'h0,        0, 1, 1, 32'hC,        32'h1000_0003, 32'h10);
    tbl[5]  = mk(0, 0, 32'h0,        0, 1, 1, 32'hC,        32'h1000_0003, 32'h14);
    tbl[6]  = mk(0, 0, 32'h0,        0, 1, 1, 32'hC,        32'h1000_0003, 32'h14);
    tbl[7]  = mk(0, 0, 32'h0,        1, 1, 1, 32'hC,        32'h1000_0003, 32'h14);
    tbl[8]  = mk(0, 0, 32'h0,        1, 1, 1, 32'h10,       32'h1000_0004, 32'h18);
    tbl[9]  = mk(0, 0, 32'h0,        1, 1, 1, 32'h14,       32'h1000_0005, 32'h1C);
    tbl[10] = mk(0, 0, 32'h0,        0, 1, 1, 32'h18,       32'h1000_0006, 32'h20);
    tbl[11] = mk(0, 1, 32'h43,       1, 0, 0, 32'h0,        32'h0,        32'h20);
    tbl[12] = mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h40);
    tbl[13] = mk(0, 0, 32'h0,        1, 1, 1, 32'h40,       32'h1000_0010, 32'h44);
    tbl[14] = mk(0, 1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0,       32'h0,        32'h48);
    tbl[15] = mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'hFFFF_FFF8);
    tbl[16] = mk(0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFF8, 32'h4FFF_FFFE, 32'hFFFF_FFFC);
    tbl[17] = mk(0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 32'h0);
    tbl[18] = mk(0, 0, 32'h0,        1, 1, 1, 32'h0,        32'h1000_0000, 32'h4);
    tbl[19] = mk(0, 0, 32'h0,        0, 1, 1, 32'h4,        32'h1000_0001, 32'h8);
    tbl[20] = mk(0, 0, 32'h0,        0, 1, 1, 32'h4,        32'h1000_0001, 32'hC);
    tbl[21] = mk(1, 1, 32'h100,      1, 0, 0, 32'h0,        32'h0,        32'hC);
    tbl[22] = mk(0, 0, 32'h0,        1, 0, 1, 32'h0,        32'h0,        32'h0);

    // Initial reset (outputs undefined before the first reset edge).
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      model_step();
    end

    // Directed vectors: streaming, backpressure, redirect, wrap, reset.
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].rst, tbl[i].rd, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].ea);
      if (tbl[i].cd) begin
        chk($sformatf("vec%0d_instr", i), instr, tbl[i].ei);
        chk($sformatf("vec%0d_pc", i), instr_pc, tbl[i].ep);
      end
      model_step();
    end

    // Ready toggling at full: every accepted PC is exactly previous + 4.
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    model_step();
    have_prev = 1'b0;
    prev_pc   = 32'h0;
    for (int i = 0; i < 24; i++) begin
      drive(1'b0, 1'b0, 32'h0, (i % 2) == 1);
      model_check();
      if (instr_valid && instr_ready) begin
        if (have_prev) chk("pc_step", instr_pc, prev_pc + 32'd4);
        prev_pc   = instr_pc;
        have_prev = 1'b1;
      end
      model_step();
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 63) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      rpc = $urandom();
      drive(r, rd, rpc, rdy);
      model_check();
      model_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
